// File: rtl/vga_axil_pkg.sv
// Shared AXI4-Lite definitions: bus widths, response codes, protection type,
// master FSM state encoding and the latched native-request payload.
package vga_axil_pkg;

  localparam int unsigned AXIL_ADDR_WIDTH = 32;
  localparam int unsigned AXIL_DATA_WIDTH = 32;
  localparam int unsigned AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    AXIL_RESP_OKAY   = 2'b00,
    AXIL_RESP_EXOKAY = 2'b01,
    AXIL_RESP_SLVERR = 2'b10,
    AXIL_RESP_DECERR = 2'b11
  } axil_resp_e;

  typedef logic [2:0] axil_prot_t;
  localparam axil_prot_t AXIL_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD   = 3'd3,
    RD_R = 3'd4,
    RSP  = 3'd5
  } axil_master_state_e;

  // Native request as captured on acceptance
  typedef struct packed {
    logic                       write;
    logic [AXIL_ADDR_WIDTH-1:0] addr;
    logic [AXIL_DATA_WIDTH-1:0] wdata;
    logic [AXIL_STRB_WIDTH-1:0] wstrb;
  } axil_req_t;

endpackage

// File: rtl/vga_axil_master_fsm.sv
// AXI4-Lite master engine: turns one native read/write request at a time into
// an AXI4-Lite transaction and returns the result on a valid/ready response port.
// Ports: clk_i/arst_n_i; native request (req_*), native response (rsp_*);
// AXI4-Lite master channels AW, W, B, AR, R. All outputs come from flops.
module vga_axil_master_fsm
  import vga_axil_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  // native request
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_write_i,
  input  logic [AXIL_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [AXIL_DATA_WIDTH-1:0] req_wdata_i,
  input  logic [AXIL_STRB_WIDTH-1:0] req_wstrb_i,
  // native response
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic                       rsp_write_o,
  output logic [AXIL_DATA_WIDTH-1:0] rsp_rdata_o,
  output axil_resp_e                 rsp_resp_o,
  // write address
  output logic [AXIL_ADDR_WIDTH-1:0] awaddr_o,
  output axil_prot_t                 awprot_o,
  output logic                       awvalid_o,
  input  logic                       awready_i,
  // write data
  output logic [AXIL_DATA_WIDTH-1:0] wdata_o,
  output logic [AXIL_STRB_WIDTH-1:0] wstrb_o,
  output logic                       wvalid_o,
  input  logic                       wready_i,
  // write response
  input  logic [1:0]                 bresp_i,
  input  logic                       bvalid_i,
  output logic                       bready_o,
  // read address
  output logic [AXIL_ADDR_WIDTH-1:0] araddr_o,
  output axil_prot_t                 arprot_o,
  output logic                       arvalid_o,
  input  logic                       arready_i,
  // read data
  input  logic [AXIL_DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]                 rresp_i,
  input  logic                       rvalid_i,
  output logic                       rready_o
);

  axil_master_state_e         state_q, state_d;
  axil_req_t                  req_q, req_d;
  logic                       req_ready_q, req_ready_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q, wvalid_d;
  logic                       aw_done_q, aw_done_d;
  logic                       w_done_q, w_done_d;
  logic                       bready_q, bready_d;
  logic                       arvalid_q, arvalid_d;
  logic                       rready_q, rready_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_write_q, rsp_write_d;
  logic [AXIL_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  axil_resp_e                 rsp_resp_q, rsp_resp_d;

  logic misaligned;
  logic aw_hs;
  logic w_hs;

  assign misaligned = ALIGN_CHECK && (req_addr_i[1:0] != 2'b00);
  assign aw_hs      = awvalid_q && awready_i;
  assign w_hs       = wvalid_q && wready_i;

  // State register and capture flops
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= AXIL_RESP_OKAY;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    req_ready_d = req_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          req_d.write = req_write_i;
          req_d.addr  = req_addr_i;
          req_d.wdata = req_wdata_i;
          req_d.wstrb = req_wstrb_i;
          req_ready_d = 1'b0;
          if (misaligned) begin
            // Local error: answer immediately, never touch the bus
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_write_d = req_write_i;
            rsp_rdata_d = '0;
            rsp_resp_d  = AXIL_RESP_SLVERR;
          end else if (req_write_i) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W complete independently; leave once both are done
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (bvalid_i && bready_q) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = axil_resp_e'(bresp_i);
        end
      end
      RD: begin
        if (arvalid_q && arready_i) begin
          state_d   = RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_R: begin
        if (rvalid_i && rready_q) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = rdata_i;
          rsp_resp_d  = axil_resp_e'(rresp_i);
        end
      end
      RSP: begin
        if (rsp_valid_q && rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_write_o = rsp_write_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_resp_o  = rsp_resp_q;
  assign awaddr_o    = req_q.addr;
  assign awprot_o    = AXIL_PROT_DEFAULT;
  assign awvalid_o   = awvalid_q;
  assign wdata_o     = req_q.wdata;
  assign wstrb_o     = req_q.wstrb;
  assign wvalid_o    = wvalid_q;
  assign bready_o    = bready_q;
  assign araddr_o    = req_q.addr;
  assign arprot_o    = AXIL_PROT_DEFAULT;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;

endmodule
